fu_dispatch_scheduler: RTL and testbench

- Sits between the two reservation stations and the execution units of the Tomasulo core.
- Picks ready entries from res1 (add/sub, 4 entries) and res2 (mul/div, 4 entries), and starts them on two ALUs and one MDU.
- Times each operation's latency, then arbitrates the single common data bus (CDB) so that one result, tagged with its ROB entry, is written back per cycle.

---
 rtl/tomasulo_pkg.sv | 49 ++++
 rtl/fu_dispatch_scheduler_if.sv | 48 ++++
 rtl/fu_timer.sv | 83 ++++++++
 rtl/fu_dispatch_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_fu_dispatch_scheduler.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// Shared opcodes, FU ids, FSM states and pick helper for the Tomasulo
// dispatch/writeback slice.
package tomasulo_pkg;

    localparam logic [3:0] OP_SUB   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0100;
    localparam logic [3:0] OP_LOAD  = 4'b0101;

    localparam int DEF_LAT_ADD = 2;
    localparam int DEF_LAT_MUL = 6;
    localparam int DEF_LAT_DIV = 8;

    // Wide enough for latency-1 of the slowest unit
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_MDU  = 2'd2
    } fu_id_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT_CDB
    } fu_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } pick_t;

    // Lowest set bit of a 4-entry candidate vector
    function automatic pick_t find_first(input logic [3:0] vec);
        pick_t p;
        p = '0;
        for (int i = 3; i >= 0; i--) begin
            if (vec[i]) begin
                p.valid = 1'b1;
                p.idx   = 2'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fu_dispatch_scheduler_if.sv
// Bundle between the reservation stations / FUs and the dispatch scheduler.
// master = station/FU side, slave = scheduler.
interface fu_dispatch_scheduler_if #(
    parameter int TAG_W = 3
);
    logic                 flush;
    logic [3:0]           rs1_ready;
    logic [15:0]          rs1_opcode;
    logic [4*TAG_W-1:0]   rs1_dest;
    logic [3:0]           rs2_ready;
    logic [15:0]          rs2_opcode;
    logic [4*TAG_W-1:0]   rs2_dest;

    logic                 alu0_start;
    logic                 alu1_start;
    logic                 mdu_start;
    logic [1:0]           alu0_idx;
    logic [1:0]           alu1_idx;
    logic [1:0]           mdu_idx;
    logic [3:0]           alu0_op;
    logic [3:0]           alu1_op;
    logic [3:0]           mdu_op;

    logic                 cdb_valid;
    logic [1:0]           cdb_src;
    logic [1:0]           cdb_rs_idx;
    logic [TAG_W-1:0]     cdb_tag;
    logic [2:0]           fu_busy;

    modport master (
        output flush, rs1_ready, rs1_opcode, rs1_dest,
               rs2_ready, rs2_opcode, rs2_dest,
        input  alu0_start, alu1_start, mdu_start,
               alu0_idx, alu1_idx, mdu_idx,
               alu0_op, alu1_op, mdu_op,
               cdb_valid, cdb_src, cdb_rs_idx, cdb_tag, fu_busy
    );

    modport slave (
        input  flush, rs1_ready, rs1_opcode, rs1_dest,
               rs2_ready, rs2_opcode, rs2_dest,
        output alu0_start, alu1_start, mdu_start,
               alu0_idx, alu1_idx, mdu_idx,
               alu0_op, alu1_op, mdu_op,
               cdb_valid, cdb_src, cdb_rs_idx, cdb_tag, fu_busy
    );

endinterface

// File: rtl/fu_timer.sv
// Per-FU latency timer: IDLE -> EXEC (count down) -> WAIT_CDB, holding the
// ROB tag and station index of the operation in flight.
module fu_timer
    import tomasulo_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [CNT_W-1:0] lat_m1,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [1:0]       idx_in,
    input  logic             grant,
    output logic             busy,
    output logic             req,
    output logic [TAG_W-1:0] tag,
    output logic [1:0]       idx
);

    fu_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [1:0]       idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
        end
    end

    // The last EXEC cycle already requests the bus so a granted result
    // appears on the CDB exactly LAT cycles after the start pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXEC;
                    cnt_d   = lat_m1;
                    tag_d   = tag_in;
                    idx_d   = idx_in;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    req     = 1'b1;
                    state_d = grant ? IDLE : WAIT_CDB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_CDB: begin
                req = 1'b1;
                if (grant) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    assign busy = (state_q != IDLE);
    assign tag  = tag_q;
    assign idx  = idx_q;

endmodule

// File: rtl/fu_dispatch_scheduler.sv
// Issues ready station entries to ALU0/ALU1/MDU and arbitrates the single CDB.
// Define CDB_RR_EN for round-robin CDB arbitration; default is MDU > ALU0 > ALU1.
module fu_dispatch_scheduler
    import tomasulo_pkg::*;
#(
    parameter int LAT_ADD = DEF_LAT_ADD,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_DIV = DEF_LAT_DIV,
    parameter int TAG_W   = 3
) (
    input logic                    clk,
    input logic                    rst,
    fu_dispatch_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] ADD_M1 = CNT_W'(LAT_ADD - 1);
    localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(LAT_MUL - 1);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(LAT_DIV - 1);

    logic [3:0]       rs1_inflight, rs2_inflight;
    logic [3:0]       rs1_cand, rs2_cand;
    pick_t            rs1_first, rs1_second, rs2_first;

    logic             alu0_pick, alu1_pick, mdu_pick;
    logic [1:0]       alu0_sel, alu1_sel, mdu_sel;
    logic [3:0]       alu0_sel_op, alu1_sel_op, mdu_sel_op;
    logic [TAG_W-1:0] alu0_sel_tag, alu1_sel_tag, mdu_sel_tag;
    logic [CNT_W-1:0] mdu_lat_m1;

    logic             alu0_busy, alu1_busy, mdu_busy;
    logic             alu0_req, alu1_req, mdu_req;
    logic [TAG_W-1:0] alu0_tag, alu1_tag, mdu_tag;
    logic [1:0]       alu0_fu_idx, alu1_fu_idx, mdu_fu_idx;
    logic [2:0]       req, grant_raw, grant;

    fu_id_e           win_src;
    logic [1:0]       win_idx;
    logic [TAG_W-1:0] win_tag;
    logic [3:0]       rs1_set, rs1_clr, rs2_set, rs2_clr;

    logic             alu0_start_q, alu1_start_q, mdu_start_q;
    logic [1:0]       alu0_idx_q, alu1_idx_q, mdu_idx_q;
    logic [3:0]       alu0_op_q, alu1_op_q, mdu_op_q;
    logic             cdb_valid_q;
    logic [1:0]       cdb_src_q, cdb_rs_idx_q;
    logic [TAG_W-1:0] cdb_tag_q;

    // Entry selection; flush suppresses every new start in its cycle
    always_comb begin
        rs1_cand   = bus.rs1_ready & ~rs1_inflight;
        rs2_cand   = bus.rs2_ready & ~rs2_inflight;
        rs1_first  = find_first(rs1_cand);
        rs1_second = find_first(rs1_cand & ~(4'b0001 << rs1_first.idx));
        rs2_first  = find_first(rs2_cand);
        alu0_pick  = 1'b0;
        alu1_pick  = 1'b0;
        mdu_pick   = 1'b0;
        alu0_sel   = rs1_first.idx;
        alu1_sel   = rs1_first.idx;
        mdu_sel    = rs2_first.idx;
        if (!bus.flush) begin
            if (!alu0_busy) begin
                alu0_pick = rs1_first.valid;
                if (!alu1_busy) begin
                    alu1_pick = rs1_second.valid;
                    alu1_sel  = rs1_second.idx;
                end
            end else if (!alu1_busy) begin
                alu1_pick = rs1_first.valid;
            end
            mdu_pick = !mdu_busy && rs2_first.valid;
        end
    end

    assign alu0_sel_op  = bus.rs1_opcode[{alu0_sel, 2'b00} +: 4];
    assign alu1_sel_op  = bus.rs1_opcode[{alu1_sel, 2'b00} +: 4];
    assign mdu_sel_op   = bus.rs2_opcode[{mdu_sel, 2'b00} +: 4];
    assign alu0_sel_tag = bus.rs1_dest[TAG_W*alu0_sel +: TAG_W];
    assign alu1_sel_tag = bus.rs1_dest[TAG_W*alu1_sel +: TAG_W];
    assign mdu_sel_tag  = bus.rs2_dest[TAG_W*mdu_sel +: TAG_W];
    assign mdu_lat_m1   = (mdu_sel_op == OP_MUL) ? MUL_M1 : DIV_M1;

    fu_timer #(.TAG_W(TAG_W)) u_alu0 (
        .clk(clk), .rst(rst), .flush(bus.flush),
        .start(alu0_pick), .lat_m1(ADD_M1),
        .tag_in(alu0_sel_tag), .idx_in(alu0_sel),
        .grant(grant[0]), .busy(alu0_busy), .req(alu0_req),
        .tag(alu0_tag), .idx(alu0_fu_idx)
    );

    fu_timer #(.TAG_W(TAG_W)) u_alu1 (
        .clk(clk), .rst(rst), .flush(bus.flush),
        .start(alu1_pick), .lat_m1(ADD_M1),
        .tag_in(alu1_sel_tag), .idx_in(alu1_sel),
        .grant(grant[1]), .busy(alu1_busy), .req(alu1_req),
        .tag(alu1_tag), .idx(alu1_fu_idx)
    );

    fu_timer #(.TAG_W(TAG_W)) u_mdu (
        .clk(clk), .rst(rst), .flush(bus.flush),
        .start(mdu_pick), .lat_m1(mdu_lat_m1),
        .tag_in(mdu_sel_tag), .idx_in(mdu_sel),
        .grant(grant[2]), .busy(mdu_busy), .req(mdu_req),
        .tag(mdu_tag), .idx(mdu_fu_idx)
    );

    assign req = {mdu_req, alu1_req, alu0_req};

`ifdef CDB_RR_EN
    logic [1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (grant[0]) begin
            rr_ptr <= 2'd1;
        end else if (grant[1]) begin
            rr_ptr <= 2'd2;
        end else if (grant[2]) begin
            rr_ptr <= 2'd0;
        end
    end

    always_comb begin
        grant_raw = 3'b000;
        case (rr_ptr)
            2'd1: begin
                if (req[1])      grant_raw = 3'b010;
                else if (req[2]) grant_raw = 3'b100;
                else if (req[0]) grant_raw = 3'b001;
            end
            2'd2: begin
                if (req[2])      grant_raw = 3'b100;
                else if (req[0]) grant_raw = 3'b001;
                else if (req[1]) grant_raw = 3'b010;
            end
            default: begin
                if (req[0])      grant_raw = 3'b001;
                else if (req[1]) grant_raw = 3'b010;
                else if (req[2]) grant_raw = 3'b100;
            end
        endcase
    end
`else
    always_comb begin
        grant_raw = 3'b000;
        if (req[2])      grant_raw = 3'b100;
        else if (req[0]) grant_raw = 3'b001;
        else if (req[1]) grant_raw = 3'b010;
    end
`endif

    assign grant = bus.flush ? 3'b000 : grant_raw;

    always_comb begin
        win_src = FU_ALU0;
        win_idx = alu0_fu_idx;
        win_tag = alu0_tag;
        if (grant[2]) begin
            win_src = FU_MDU;
            win_idx = mdu_fu_idx;
            win_tag = mdu_tag;
        end else if (grant[1]) begin
            win_src = FU_ALU1;
            win_idx = alu1_fu_idx;
            win_tag = alu1_tag;
        end
    end

    // In-flight masks keep a still-ready entry from being issued twice
    always_comb begin
        rs1_set = '0;
        rs1_clr = '0;
        rs2_set = '0;
        rs2_clr = '0;
        if (alu0_pick) rs1_set = rs1_set | (4'b0001 << alu0_sel);
        if (alu1_pick) rs1_set = rs1_set | (4'b0001 << alu1_sel);
        if (mdu_pick)  rs2_set = 4'b0001 << mdu_sel;
        if (grant[0])  rs1_clr = rs1_clr | (4'b0001 << alu0_fu_idx);
        if (grant[1])  rs1_clr = rs1_clr | (4'b0001 << alu1_fu_idx);
        if (grant[2])  rs2_clr = 4'b0001 << mdu_fu_idx;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rs1_inflight <= '0;
            rs2_inflight <= '0;
        end else begin
            rs1_inflight <= (rs1_inflight & ~rs1_clr) | rs1_set;
            rs2_inflight <= (rs2_inflight & ~rs2_clr) | rs2_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu0_start_q <= 1'b0;
            alu1_start_q <= 1'b0;
            mdu_start_q  <= 1'b0;
            alu0_idx_q   <= '0;
            alu1_idx_q   <= '0;
            mdu_idx_q    <= '0;
            alu0_op_q    <= '0;
            alu1_op_q    <= '0;
            mdu_op_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_src_q    <= '0;
            cdb_rs_idx_q <= '0;
            cdb_tag_q    <= '0;
        end else begin
            alu0_start_q <= alu0_pick;
            alu1_start_q <= alu1_pick;
            mdu_start_q  <= mdu_pick;
            alu0_idx_q   <= alu0_pick ? alu0_sel : 2'b00;
            alu1_idx_q   <= alu1_pick ? alu1_sel : 2'b00;
            mdu_idx_q    <= mdu_pick ? mdu_sel : 2'b00;
            alu0_op_q    <= alu0_pick ? alu0_sel_op : 4'b0000;
            alu1_op_q    <= alu1_pick ? alu1_sel_op : 4'b0000;
            mdu_op_q     <= mdu_pick ? mdu_sel_op : 4'b0000;
            cdb_valid_q  <= |grant;
            cdb_src_q    <= (|grant) ? win_src : 2'b00;
            cdb_rs_idx_q <= (|grant) ? win_idx : 2'b00;
            cdb_tag_q    <= (|grant) ? win_tag : '0;
        end
    end

    assign bus.alu0_start = alu0_start_q;
    assign bus.alu1_start = alu1_start_q;
    assign bus.mdu_start  = mdu_start_q;
    assign bus.alu0_idx   = alu0_idx_q;
    assign bus.alu1_idx   = alu1_idx_q;
    assign bus.mdu_idx    = mdu_idx_q;
    assign bus.alu0_op    = alu0_op_q;
    assign bus.alu1_op    = alu1_op_q;
    assign bus.mdu_op     = mdu_op_q;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_src    = cdb_src_q;
    assign bus.cdb_rs_idx = cdb_rs_idx_q;
    assign bus.cdb_tag    = cdb_tag_q;
    assign bus.fu_busy    = {mdu_busy, alu1_busy, alu0_busy};

endmodule

// File: tb/tb_fu_dispatch_scheduler.sv
// Directed bench for fu_dispatch_scheduler (default fixed-priority CDB build).
module tb_fu_dispatch_scheduler;
    import tomasulo_pkg::*;

    localparam int TAG_W = 3;

    logic clk = 1'b0;
    logic rst;
    int   total_compared   = 0;
    int   total_mismatched = 0;

    fu_dispatch_scheduler_if #(.TAG_W(TAG_W)) bus ();

    fu_dispatch_scheduler #(
        .LAT_ADD(2), .LAT_MUL(6), .LAT_DIV(8), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_compared++;
        if (observed !== expected) begin
            total_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r1, input logic [3:0] r2);
        bus.rs1_ready = r1;
        bus.rs2_ready = r2;
    endtask

    task automatic setEntry1(input int e, input logic [3:0] op, input logic [TAG_W-1:0] tag);
        bus.rs1_opcode[4*e +: 4]         = op;
        bus.rs1_dest[TAG_W*e +: TAG_W]   = tag;
    endtask

    task automatic setEntry2(input int e, input logic [3:0] op, input logic [TAG_W-1:0] tag);
        bus.rs2_opcode[4*e +: 4]         = op;
        bus.rs2_dest[TAG_W*e +: TAG_W]   = tag;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        int  starts;
        int  cdbs;
        int  alu_lat;
        int  mdu_lat;
        int  last_tag;
        bit  seen;

        rst = 1'b1;
        bus.flush = 1'b0;
        bus.rs1_opcode = '0;
        bus.rs1_dest   = '0;
        bus.rs2_opcode = '0;
        bus.rs2_dest   = '0;
        applyStimulus(4'b0000, 4'b0000);
        repeat (3) tick();
        checkOutput("reset_cdb_valid", bus.cdb_valid, 0);
        checkOutput("reset_starts", {bus.alu0_start, bus.alu1_start, bus.mdu_start}, 0);
        checkOutput("reset_fu_busy", bus.fu_busy, 0);
        rst = 1'b0;
        tick();

        // Single add
        setEntry1(0, OP_ADD, 3'd5);
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("add_alu0_start", bus.alu0_start, 1);
        checkOutput("add_alu0_idx", bus.alu0_idx, 0);
        checkOutput("add_alu0_op", bus.alu0_op, OP_ADD);
        checkOutput("add_alu1_start", bus.alu1_start, 0);
        checkOutput("add_fu_busy_run", bus.fu_busy, 3'b001);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("add_cdb_early", bus.cdb_valid, 0);
        tick();
        checkOutput("add_cdb_valid", bus.cdb_valid, 1);
        checkOutput("add_cdb_src", bus.cdb_src, 0);
        checkOutput("add_cdb_tag", bus.cdb_tag, 5);
        checkOutput("add_cdb_rs_idx", bus.cdb_rs_idx, 0);
        checkOutput("add_fu_busy_done", bus.fu_busy, 3'b000);
        tick();
        checkOutput("add_cdb_once", bus.cdb_valid, 0);

        // Ready held high: one start until the grant
        setEntry1(0, OP_SUB, 3'd6);
        applyStimulus(4'b0001, 4'b0000);
        starts = 0;
        seen   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!seen) starts += int'(bus.alu0_start) + int'(bus.alu1_start);
            if (bus.cdb_valid) seen = 1'b1;
        end
        checkOutput("hold_single_issue", starts, 1);
        checkOutput("hold_cdb_seen", seen, 1);
        applyStimulus(4'b0000, 4'b0000);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("hold_flush_busy", bus.fu_busy, 0);

        // Dual ALU issue and back-to-back writeback
        setEntry1(1, OP_ADD, 3'd1);
        setEntry1(2, OP_SUB, 3'd2);
        applyStimulus(4'b0110, 4'b0000);
        tick();
        checkOutput("dual_alu0_start", bus.alu0_start, 1);
        checkOutput("dual_alu0_idx", bus.alu0_idx, 1);
        checkOutput("dual_alu1_start", bus.alu1_start, 1);
        checkOutput("dual_alu1_idx", bus.alu1_idx, 2);
        checkOutput("dual_alu1_op", bus.alu1_op, OP_SUB);
        checkOutput("dual_fu_busy", bus.fu_busy, 3'b011);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("dual_cdb_early", bus.cdb_valid, 0);
        tick();
        checkOutput("dual_first_valid", bus.cdb_valid, 1);
        checkOutput("dual_first_src", bus.cdb_src, 0);
        checkOutput("dual_first_tag", bus.cdb_tag, 1);
        checkOutput("dual_first_idx", bus.cdb_rs_idx, 1);
        tick();
        checkOutput("dual_second_valid", bus.cdb_valid, 1);
        checkOutput("dual_second_src", bus.cdb_src, 1);
        checkOutput("dual_second_tag", bus.cdb_tag, 2);
        checkOutput("dual_second_idx", bus.cdb_rs_idx, 2);
        tick();
        checkOutput("dual_cdb_end", bus.cdb_valid, 0);
        checkOutput("dual_fu_busy_end", bus.fu_busy, 0);

        // MUL then back-to-back DIV on the MDU
        setEntry2(3, OP_MUL, 3'd3);
        setEntry2(0, OP_DIV, 3'd4);
        applyStimulus(4'b0000, 4'b1000);
        tick();
        checkOutput("mul_start", bus.mdu_start, 1);
        checkOutput("mul_idx", bus.mdu_idx, 3);
        checkOutput("mul_op", bus.mdu_op, OP_MUL);
        checkOutput("mul_fu_busy", bus.fu_busy, 3'b100);
        applyStimulus(4'b0000, 4'b1001);
        n = 0;
        starts = 0;
        do begin
            tick();
            n++;
            starts += int'(bus.mdu_start);
        end while (!bus.cdb_valid && n < 20);
        checkOutput("mul_latency", n, 6);
        checkOutput("mul_no_start_busy", starts, 0);
        checkOutput("mul_cdb_src", bus.cdb_src, 2);
        checkOutput("mul_cdb_tag", bus.cdb_tag, 3);
        checkOutput("mul_cdb_idx", bus.cdb_rs_idx, 3);
        applyStimulus(4'b0000, 4'b0001);
        tick();
        checkOutput("div_start", bus.mdu_start, 1);
        checkOutput("div_idx", bus.mdu_idx, 0);
        checkOutput("div_op", bus.mdu_op, OP_DIV);
        applyStimulus(4'b0000, 4'b0000);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cdb_valid && n < 20);
        checkOutput("div_latency", n, 8);
        checkOutput("div_cdb_tag", bus.cdb_tag, 4);
        tick();

        // DIV and ADD finishing together: MDU wins
        setEntry2(1, OP_DIV, 3'd6);
        applyStimulus(4'b0000, 4'b0010);
        tick();
        checkOutput("conf_mdu_start", bus.mdu_start, 1);
        checkOutput("conf_mdu_idx", bus.mdu_idx, 1);
        applyStimulus(4'b0000, 4'b0000);
        repeat (5) tick();
        setEntry1(0, OP_ADD, 3'd7);
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("conf_alu0_start", bus.alu0_start, 1);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("conf_cdb_early", bus.cdb_valid, 0);
        tick();
        checkOutput("conf_first_valid", bus.cdb_valid, 1);
        checkOutput("conf_first_src", bus.cdb_src, 2);
        checkOutput("conf_first_tag", bus.cdb_tag, 6);
        tick();
        checkOutput("conf_second_valid", bus.cdb_valid, 1);
        checkOutput("conf_second_src", bus.cdb_src, 0);
        checkOutput("conf_second_tag", bus.cdb_tag, 7);
        tick();
        checkOutput("conf_cdb_end", bus.cdb_valid, 0);

        // Flush while MDU executes and ALU0 has a finished result pending
        setEntry2(3, OP_MUL, 3'd3);
        applyStimulus(4'b0000, 4'b1000);
        tick();
        setEntry1(0, OP_ADD, 3'd1);
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("flush_pre_busy", bus.fu_busy, 3'b101);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("flush_pre_cdb", bus.cdb_valid, 0);
        bus.flush = 1'b1;
        setEntry1(2, OP_SUB, 3'd2);
        applyStimulus(4'b0100, 4'b0000);
        tick();
        bus.flush = 1'b0;
        checkOutput("flush_fu_busy", bus.fu_busy, 0);
        checkOutput("flush_cdb_valid", bus.cdb_valid, 0);
        checkOutput("flush_no_start", bus.alu0_start, 0);
        tick();
        checkOutput("flush_fresh_start", bus.alu0_start, 1);
        checkOutput("flush_fresh_idx", bus.alu0_idx, 2);
        applyStimulus(4'b0000, 4'b0000);
        cdbs = 0;
        last_tag = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.cdb_valid) begin
                cdbs++;
                last_tag = int'(bus.cdb_tag);
            end
        end
        checkOutput("flush_cdb_count", cdbs, 1);
        checkOutput("flush_cdb_tag", last_tag, 2);

        // Non add/sub and non mul opcodes
        setEntry1(3, 4'b1111, 3'd5);
        setEntry2(2, OP_STORE, 3'd6);
        applyStimulus(4'b1000, 4'b0100);
        tick();
        checkOutput("other_alu0_start", bus.alu0_start, 1);
        checkOutput("other_alu0_op", bus.alu0_op, 4'b1111);
        checkOutput("other_mdu_op", bus.mdu_op, OP_STORE);
        applyStimulus(4'b0000, 4'b0000);
        alu_lat = 0;
        mdu_lat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.cdb_valid && bus.cdb_src == 2'd0) alu_lat = k;
            if (bus.cdb_valid && bus.cdb_src == 2'd2) mdu_lat = k;
        end
        checkOutput("other_alu_latency", alu_lat, 2);
        checkOutput("other_mdu_latency", mdu_lat, 8);

        // Reset in the middle of operations
        setEntry1(0, OP_ADD, 3'd1);
        setEntry2(0, OP_MUL, 3'd2);
        applyStimulus(4'b0001, 4'b0001);
        tick();
        applyStimulus(4'b0000, 4'b0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_fu_busy", bus.fu_busy, 0);
        checkOutput("rst_mid_cdb", bus.cdb_valid, 0);
        checkOutput("rst_mid_starts", {bus.alu0_start, bus.alu1_start, bus.mdu_start}, 0);
        cdbs = 0;
        repeat (10) begin
            tick();
            cdbs += int'(bus.cdb_valid);
        end
        checkOutput("rst_mid_no_cdb", cdbs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", total_compared, total_mismatched);
        $finish;
    end

endmodule
